// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        filled;
   } fetch_entry_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order circular buffer of fetch entries, allocated at issue and filled by responses.
// Pointers carry one extra wrap bit so count and unfilled fall out of plain subtraction.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         alloc,
   input  logic [31:0]  alloc_pc,
   input  logic         fill,
   input  logic [31:0]  fill_instr,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [PW:0]  count,
   output logic [PW:0]  unfilled
);

   fetch_entry_t mem [DEPTH];
   logic [PW:0]  alloc_ptr, fill_ptr, head_ptr;

   assign head     = mem[head_ptr[PW-1:0]];
   assign count    = alloc_ptr - head_ptr;
   assign unfilled = alloc_ptr - fill_ptr;

   // alloc and fill never hit the same slot: fill needs unfilled>0, alloc needs count<DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
      end else begin
         if (alloc) begin
            mem[alloc_ptr[PW-1:0]].pc     <= alloc_pc;
            mem[alloc_ptr[PW-1:0]].filled <= 1'b0;
            alloc_ptr                     <= alloc_ptr + 1'b1;
         end
         if (fill) begin
            mem[fill_ptr[PW-1:0]].instr  <= fill_instr;
            mem[fill_ptr[PW-1:0]].filled <= 1'b1;
            fill_ptr                     <= fill_ptr + 1'b1;
         end
         if (pop) head_ptr <= head_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage; issues word reads, queues responses in order, hands {instr, pc} to decode.
// Redirects squash the queue and count the orphaned in-flight responses so they are discarded on return.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   output logic        pc_stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam int PW = ptr_w(DEPTH);
   localparam int DW = PW + 4;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   fetch_entry_t  head;
   logic [PW:0]   count, unfilled;
   logic [DW-1:0] drop_cnt, drop_nxt;
   logic          fill, pop, rsp_hit;

   assign imem_req  = rst_n && !flush && count != FULL;
   assign pc_stall  = rst_n && !flush && !imem_req;
   assign imem_addr = {pc_in[31:2], 2'b00};
   assign id_valid  = count != '0 && head.filled;
   assign id_instr  = id_valid ? head.instr : NOP_INSTR;
   assign id_pc     = id_valid ? head.pc : 32'h0;
   assign pop       = id_valid && id_ready && !flush;
   assign fill      = imem_rvalid && !flush && drop_cnt == '0 && unfilled != '0;
   // a response consumes either an outstanding drop or the oldest unfilled entry
   assign rsp_hit   = imem_rvalid && (drop_cnt != '0 || unfilled != '0);

   always_comb begin
      drop_nxt = flush ? drop_cnt + DW'(unfilled) - DW'(rsp_hit)
                       : drop_cnt - DW'(imem_rvalid && drop_cnt != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= '0;
      else        drop_cnt <= drop_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst_n && imem_rvalid) assert (drop_cnt != '0 || unfilled != '0);
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc      (imem_req),
      .alloc_pc   (imem_addr),
      .fill       (fill),
      .fill_instr (imem_rdata),
      .pop        (pop),
      .head       (head),
      .count      (count),
      .unfilled   (unfilled)
   );

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the pipelined RV32I core, directly downstream of the PC register. Each cycle it takes the current PC, issues a word read to instruction memory, and tracks up to DEPTH outstanding fetches in an in-order queue. It delivers {instr, pc} pairs to decode over a valid/ready handshake. It back-pressures the PC register through `pc_stall` and, on a branch/jump redirect, squashes every queued and in-flight fetch.

## Interface
- DEPTH, 4, queue entries (allocated + filled); power of two, ≥2; DEPTH ≥ 4 needed for 1 instr/cycle with a 1-cycle memory
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pc_in  in  32  current PC from the PC register
- pc_stall  out  1  1 = PC register must hold
- flush  in  1  redirect from EX; squash everything this cycle
- imem_req  out  1  fetch request, always accepted by memory
- imem_addr  out  32  word address `{pc_in[31:2], 2'b00}`
- imem_rvalid  in  1  response valid; responses are in request order, latency ≥1 cycle
- imem_rdata  in  32  instruction word
- id_valid  out  1  head entry holds a fetched instruction
- id_instr  out  32  head instruction; 32'h0000_0013 (NOP) when id_valid=0
- id_pc  out  32  PC of head instruction; 0 when id_valid=0
- id_ready  in  1  decode accepts head this cycle

## Operation
- Queue entry holds pc, instr and a filled bit. It is allocated at issue (pc stored) and filled by the next non-dropped response, in order.
- Pointers:
  - alloc_ptr advances on issue.
  - fill_ptr advances on an accepted response.
  - head_ptr advances on pop.
  - count = allocated entries.
- Issue: `imem_req = rst_n && !flush && count < DEPTH`. There is no same-cycle pop bypass, so `pc_stall` never depends on id_ready.
- `pc_stall = !flush && !imem_req`. During flush, pc_stall=0 so the PC register loads the redirect target.
- Pop when `id_valid && id_ready`. `id_valid = count>0 && head.filled`.
- Simultaneous issue + pop: count unchanged.
- Flush:
  - All entries invalidated and pointers reset to 0 at the next edge.
  - No issue or pop that cycle.
  - drop_cnt loads the number of allocated-but-unfilled entries, minus 1 if imem_rvalid is high that cycle.
- Drop: while drop_cnt>0, each imem_rvalid decrements drop_cnt and discards the data.
- Issue after flush is allowed next cycle even if drop_cnt>0. New responses arrive after all dropped ones (in-order memory).
- Flush while drop_cnt>0: drop_cnt adds the newly unfilled count, using the same formula.
- imem_rvalid with no unfilled entry and drop_cnt=0 is a protocol error. Assert in simulation; data ignored.

## Timing
- Reset (async): count=0, pointers=0, drop_cnt=0, imem_req=0, pc_stall=0, id_valid=0, id_instr=NOP, id_pc=0, imem_addr follows pc_in.
- Issue at cycle N with response at N+L gives entry filled at edge end of N+L. id_valid is earliest at N+L+1.
- Decode-visible latency is therefore L+1 cycles. With L=1 and DEPTH=4, steady-state throughput is 1 instr/cycle.
- Queue full (count=DEPTH): pc_stall=1 until a pop completes. The first issue follows in the cycle after the pop.
- Reset asserted mid-operation: all state cleared immediately. In-flight memory responses after reset release are the bench's responsibility, since imem resets too.
- All outputs are combinational from registered state plus flush and pc_in. There is no input-to-output path from id_ready.

## Structure
- `fetch_pkg`: NOP_INSTR constant, `fetch_entry_t` struct {pc, instr, filled}, DEPTH-derived pointer width function.
- Sub-module `fetch_queue`: circular buffer with alloc/fill/pop ports, flush clear, and count output. `instr_fetch_unit` holds issue logic, drop counter and output muxing.

## Test plan
- Reset release, pc_in increments by 4, memory L=1, id_ready=1: id_valid first high 2 cycles after first imem_req, then continuous. id_pc = 0, 4, 8…
- id_ready=0 for 10 cycles:
  - Exactly 4 issues, then pc_stall=1.
  - Raising id_ready gives pops in PC order 0..C.
  - Issue resumes the cycle after the first pop.
- L=3 memory, flush with 3 fetches in flight and rvalid low:
  - drop_cnt=3; the next 3 responses are discarded.
  - First delivered instr carries the redirect pc (e.g. 0x100).
- Flush in the same cycle as imem_rvalid with 2 unfilled: drop_cnt=1. The flush-cycle data never appears on id_instr.
- Back-to-back flushes 2 cycles apart with L=3: no stale instruction reaches decode, and id_pc after the second flush equals the second target.
- Async rst_n pulse mid-stream with queue full: id_valid=0, id_instr=0x00000013, imem_req=0 immediately. Normal fetch from pc 0 after release.
